// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned DEF_SET_WIDTH    = 4;
  localparam int unsigned DEF_OFFSET_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dcache_state_t;

  // One word-serial memory command as seen on the memory side of the cache.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Word offset within a line (byte bits [1:0] are dropped).
  function automatic logic [ADDR_W-1:0] addr_offset(input logic [ADDR_W-1:0] a,
                                                     input int unsigned ow);
    return (a >> 2) & ((ADDR_W'(1) << ow) - ADDR_W'(1));
  endfunction

  // Set index, sitting directly above the word offset.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a,
                                                    input int unsigned ow,
                                                    input int unsigned sw);
    return (a >> (2 + ow)) & ((ADDR_W'(1) << sw) - ADDR_W'(1));
  endfunction

  // Tag: everything above the index.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                  input int unsigned ow,
                                                  input int unsigned sw);
    return a >> (2 + ow + sw);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Core-side request/response and memory-side word bus of the data cache.
interface dcache_if;
  import dcache_pkg::*;

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Environment side: the core plus main memory.
  modport master (
    output en, we, addr, wdata, mem_rdata, mem_ack,
    input  rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Cache side.
  modport slave (
    input  en, we, addr, wdata, mem_rdata, mem_ack,
    output rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_store.sv
// Line storage: valid/dirty/tag/data arrays, two async read ports, one sync write port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned SET_WIDTH    = DEF_SET_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int unsigned TAG_W        = ADDR_W - 2 - DEF_OFFSET_WIDTH - DEF_SET_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SET_WIDTH-1:0]    lk_index_i,
  input  logic [OFFSET_WIDTH-1:0] lk_offset_i,
  output logic                    lk_valid_o,
  output logic                    lk_dirty_o,
  output logic [TAG_W-1:0]        lk_tag_o,
  output logic [DATA_W-1:0]       lk_word_o,
  input  logic [SET_WIDTH-1:0]    wb_index_i,
  input  logic [OFFSET_WIDTH-1:0] wb_offset_i,
  output logic [DATA_W-1:0]       wb_word_o,
  input  logic                    wr_en_i,
  input  logic [SET_WIDTH-1:0]    wr_index_i,
  input  logic [OFFSET_WIDTH-1:0] wr_offset_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic                    set_dirty_i,
  input  logic                    fill_done_i,
  input  logic [TAG_W-1:0]        fill_tag_i
);

  localparam int unsigned SETS  = 1 << SET_WIDTH;
  localparam int unsigned WORDS = SETS << OFFSET_WIDTH;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [WORDS];

  assign lk_valid_o = valid_q[lk_index_i];
  assign lk_dirty_o = dirty_q[lk_index_i];
  assign lk_tag_o   = tag_q[lk_index_i];
  assign lk_word_o  = data_q[{lk_index_i, lk_offset_i}];
  assign wb_word_o  = data_q[{wb_index_i, wb_offset_i}];

  // Line status bits; a completed fill leaves the line valid and clean.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_en_i && set_dirty_i) dirty_q[wr_index_i] <= 1'b1;
      if (fill_done_i) begin
        valid_q[wr_index_i] <= 1'b1;
        dirty_q[wr_index_i] <= 1'b0;
      end
    end
  end

  // Tag and data payload; never cleared, the valid bit guards them.
  always_ff @(posedge clk) begin
    if (reset && wr_en_i) data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
    if (reset && fill_done_i) tag_q[wr_index_i] <= fill_tag_i;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned SET_WIDTH    = DEF_SET_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input logic     clk,
  input logic     reset,
  dcache_if.slave bus
);

  localparam int unsigned TAG_W      = ADDR_W - 2 - OFFSET_WIDTH - SET_WIDTH;
  localparam int unsigned LINE_WORDS = 1 << OFFSET_WIDTH;

  dcache_state_t           state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [SET_WIDTH-1:0]    index_q, index_d;
  logic [TAG_W-1:0]        old_tag_q, old_tag_d;
  logic [TAG_W-1:0]        new_tag_q, new_tag_d;

  logic [SET_WIDTH-1:0]    req_index;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic [TAG_W-1:0]        req_tag;
  logic                    lk_valid, lk_dirty;
  logic [TAG_W-1:0]        lk_tag;
  logic [DATA_W-1:0]       lk_word, wb_word;
  logic                    lookup_hit_c, store_hit_c, mem_req_c, fill_done_c, wr_en_c;
  logic [SET_WIDTH-1:0]    wr_index_c;
  logic [OFFSET_WIDTH-1:0] wr_offset_c;
  logic [DATA_W-1:0]       wr_data_c;
  mem_cmd_t                mem_cmd_c;

  assign req_offset   = OFFSET_WIDTH'(addr_offset(bus.addr, OFFSET_WIDTH));
  assign req_index    = SET_WIDTH'(addr_index(bus.addr, OFFSET_WIDTH, SET_WIDTH));
  assign req_tag      = TAG_W'(addr_tag(bus.addr, OFFSET_WIDTH, SET_WIDTH));
  assign lookup_hit_c = lk_valid && (lk_tag == req_tag);
  assign store_hit_c  = bus.en && bus.we && (state_q == IDLE) && lookup_hit_c;

  assign bus.hit       = !bus.en || ((state_q == IDLE) && lookup_hit_c);
  assign bus.rdata     = lk_word;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_cmd_c.we;
  assign bus.mem_addr  = mem_cmd_c.addr;
  assign bus.mem_wdata = mem_cmd_c.wdata;

  dcache_line_store #(
    .SET_WIDTH   (SET_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_W       (TAG_W)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .lk_index_i (req_index),
    .lk_offset_i(req_offset),
    .lk_valid_o (lk_valid),
    .lk_dirty_o (lk_dirty),
    .lk_tag_o   (lk_tag),
    .lk_word_o  (lk_word),
    .wb_index_i (index_q),
    .wb_offset_i(cnt_q),
    .wb_word_o  (wb_word),
    .wr_en_i    (wr_en_c),
    .wr_index_i (wr_index_c),
    .wr_offset_i(wr_offset_c),
    .wr_data_i  (wr_data_c),
    .set_dirty_i(store_hit_c),
    .fill_done_i(fill_done_c),
    .fill_tag_i (new_tag_q)
  );

  // State, word counter and miss latches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      index_q   <= '0;
      old_tag_q <= '0;
      new_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      index_q   <= index_d;
      old_tag_q <= old_tag_d;
      new_tag_q <= new_tag_d;
    end
  end

  // Miss sequencing, memory command and line-store write port steering.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    index_d     = index_q;
    old_tag_d   = old_tag_q;
    new_tag_d   = new_tag_q;
    mem_req_c   = 1'b0;
    mem_cmd_c   = '0;
    fill_done_c = 1'b0;
    wr_en_c     = store_hit_c;
    wr_index_c  = req_index;
    wr_offset_c = req_offset;
    wr_data_c   = bus.wdata;
    unique case (state_q)
      IDLE: begin
        if (bus.en && !lookup_hit_c) begin
          index_d   = req_index;
          old_tag_d = lk_tag;
          new_tag_d = req_tag;
          cnt_d     = '0;
          state_d   = (lk_valid && lk_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req_c       = 1'b1;
        mem_cmd_c.we    = 1'b1;
        mem_cmd_c.addr  = {old_tag_q, index_q, cnt_q, 2'b00};
        mem_cmd_c.wdata = wb_word;
        if (bus.mem_ack) begin
          cnt_d = cnt_q + OFFSET_WIDTH'(1);
          if (cnt_q == OFFSET_WIDTH'(LINE_WORDS - 1)) state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req_c      = 1'b1;
        mem_cmd_c.addr = {new_tag_q, index_q, cnt_q, 2'b00};
        if (bus.mem_ack) begin
          wr_en_c     = 1'b1;
          wr_index_c  = index_q;
          wr_offset_c = cnt_q;
          wr_data_c   = bus.mem_rdata;
          cnt_d       = cnt_q + OFFSET_WIDTH'(1);
          if (cnt_q == OFFSET_WIDTH'(LINE_WORDS - 1)) begin
            fill_done_c = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized traffic.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk;
  logic reset;
  dcache_if bus();

  dcache_ctrl #(.SET_WIDTH(4), .OFFSET_WIDTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference cache contents: what a direct-mapped write-back cache must hold.
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sys_mem [logic [31:0]];
  mem_cmd_t    exp_q[$];
  logic [31:0] exp_rdata;
  bit          chk_on;
  bit          spurious;
  int          fixed_delay;
  int          wb_acks = 0;
  int          rd_acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] sys_get(input logic [31:0] a);
    return sys_mem.exists(a) ? sys_mem[a] : mem_init(a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Predict the memory traffic and load data of one access, then apply it.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [3:0]  idx;
    logic [1:0]  off;
    logic [23:0] tg;
    logic [31:0] la;
    mem_cmd_t    c;
    idx = a[7:4];
    off = a[3:2];
    tg  = a[31:8];
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < 4; k++) begin
          la      = {m_tag[idx], idx, 4'(k * 4)};
          c.we    = 1'b1;
          c.addr  = la;
          c.wdata = m_data[idx][k];
          exp_q.push_back(c);
          ref_mem[la] = m_data[idx][k];
        end
      end
      for (int k = 0; k < 4; k++) begin
        la      = {tg, idx, 4'(k * 4)};
        c.we    = 1'b0;
        c.addr  = la;
        c.wdata = '0;
        exp_q.push_back(c);
        m_data[idx][k] = ref_get(la);
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    exp_rdata = m_data[idx][off];
    if (w) begin
      m_data[idx][off] = d;
      m_dirty[idx]     = 1'b1;
    end
  endtask

  // Main memory: acks each requested word after a short delay.
  initial begin : responder
    int wait_left;
    wait_left     = -1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ack = 1'b0;
      if (spurious) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end else if (bus.mem_req) begin
        if (wait_left < 0) wait_left = (fixed_delay < 0) ? int'($urandom_range(0, 2)) : fixed_delay;
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            sys_mem[bus.mem_addr] = bus.mem_wdata;
            wb_acks++;
          end else begin
            bus.mem_rdata = sys_get(bus.mem_addr);
            rd_acks++;
          end
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  // Every-cycle compare of hit, load data and memory commands against the model.
  always @(negedge clk) begin
    if (reset && chk_on) begin
      if (!bus.en) begin
        chk("hit_no_req", 32'(bus.hit), 32'd1);
      end else begin
        chk("hit", 32'(bus.hit), 32'(exp_q.size() == 0));
        if (exp_q.size() == 0 && !bus.we && bus.hit) chk("rdata", bus.rdata, exp_rdata);
      end
      if (bus.mem_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(bus.mem_req), 32'd0);
        end else begin
          chk("mem_we", 32'(bus.mem_we), 32'(exp_q[0].we));
          chk("mem_addr", bus.mem_addr, exp_q[0].addr);
          if (exp_q[0].we) chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
          if (bus.mem_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One core access: hold the request until hit, then let the edge consume it.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lowc, output logic [31:0] rd);
    bit done;
    model_access(w, a, d);
    bus.en    = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    lowc      = 0;
    done      = 1'b0;
    rd        = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (bus.hit) begin
        done = 1'b1;
        break;
      end
      lowc++;
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    rd = bus.rdata;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin : main
    int          lowc, wb0, rd0;
    logic [31:0] rd;
    bit          reached;
    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    chk_on      = 1'b0;
    spurious    = 1'b0;
    fixed_delay = 2;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      ref_mem[32'h100 + 32'(k * 4)] = 32'h11 * 32'(k + 1);
      sys_mem[32'h100 + 32'(k * 4)] = 32'h11 * 32'(k + 1);
    end
    ref_mem[32'h200] = 32'h55AA_0001;
    sys_mem[32'h200] = 32'h55AA_0001;
    ref_mem[32'h300] = 32'h3000_0000;
    sys_mem[32'h300] = 32'h3000_0000;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd1);
    chk_on = 1'b1;

    // Idle request port with a stray ack.
    @(posedge clk);
    #1 bus.addr = 32'hFFFF_FFFC;
    repeat (3) @(posedge clk);
    #1 spurious = 1'b1;
    @(posedge clk);
    #1 spurious = 1'b0;
    @(negedge clk);
    chk("t1_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t1_hit", 32'(bus.hit), 32'd1);
    @(posedge clk);
    #1;

    // Cold load, then a hit in the same line.
    wb0 = wb_acks; rd0 = rd_acks;
    access(1'b0, 32'h0000_0100, 32'h0, lowc, rd);
    chk("t2_rdata", rd, 32'h11);
    chk("t2_reads", 32'(rd_acks - rd0), 32'd4);
    chk("t2_writes", 32'(wb_acks - wb0), 32'd0);
    access(1'b0, 32'h0000_0108, 32'h0, lowc, rd);
    chk("t2_hit_rdata", rd, 32'h33);
    chk("t2_hit_lat", 32'(lowc), 32'd0);

    // Store hit and read-back.
    access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, lowc, rd);
    chk("t3_store_lat", 32'(lowc), 32'd0);
    access(1'b0, 32'h0000_0104, 32'h0, lowc, rd);
    chk("t3_rdata", rd, 32'hDEAD_BEEF);

    // Dirty eviction: write-back then refill.
    wb0 = wb_acks; rd0 = rd_acks;
    access(1'b0, 32'h0000_0200, 32'h0, lowc, rd);
    chk("t4_rdata", rd, 32'h55AA_0001);
    chk("t4_writes", 32'(wb_acks - wb0), 32'd4);
    chk("t4_reads", 32'(rd_acks - rd0), 32'd4);
    chk("t4_mem_100", sys_get(32'h100), 32'h11);
    chk("t4_mem_104", sys_get(32'h104), 32'hDEAD_BEEF);
    chk("t4_mem_10c", sys_get(32'h10C), 32'h44);

    // Reset in the middle of a refill.
    model_access(1'b0, 32'h0000_0300, 32'h0);
    bus.en   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h0000_0300;
    rd0      = rd_acks;
    reached  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (rd_acks - rd0 >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) chk("t5_timeout", 32'd0, 32'd1);
    reset  = 1'b0;
    bus.en = 1'b0;
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_mem_req", 32'(bus.mem_req), 32'd0);
    @(posedge clk);
    #1;
    rd0 = rd_acks;
    access(1'b0, 32'h0000_0300, 32'h0, lowc, rd);
    chk("t5_reads", 32'(rd_acks - rd0), 32'd4);
    chk("t5_rdata", rd, 32'h3000_0000);

    // Clean victim: refill only.
    wb0 = wb_acks; rd0 = rd_acks;
    access(1'b0, 32'h0000_0104, 32'h0, lowc, rd);
    chk("t6_rdata", rd, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_1104, 32'h0, lowc, rd);
    chk("t6_writes", 32'(wb_acks - wb0), 32'd0);
    chk("t6_reads", 32'(rd_acks - rd0), 32'd8);

    // Randomized traffic over a few conflicting tags and indices.
    fixed_delay = -1;
    for (int i = 0; i < 250; i++) begin
      logic [23:0] tg;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: tg = 24'h000000;
        1: tg = 24'h000011;
        2: tg = 24'h12345A;
        default: tg = 24'hFFFFFF;
      endcase
      a = {tg, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom, lowc, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the pipeline's memory stage. It consumes the core's data-side request (`dcen`, `MemWrite`, `DataAddr`, `WriteData`) and returns `ReadData` plus `Dhit`. While `Dhit` is low the core stalls every pipeline register. Misses are serviced over a word-serial req/ack bus to main memory.

## Interface
Parameters:
- `SET_WIDTH`, default 4: index bits; the cache has 2^SET_WIDTH lines.
- `OFFSET_WIDTH`, default 2: word-offset bits; LINE_WORDS = 2^OFFSET_WIDTH.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  request valid (core `dcen`).
- `we`  in  1  store when 1, load when 0.
- `addr`  in  32  byte address. [1:0] ignored. Offset = [OFFSET_WIDTH+1:2]. Index = next SET_WIDTH bits. Tag = remainder.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, valid when `en & ~we & hit`.
- `hit`  out  1  1 = request complete or no request (core `Dhit`).
- `mem_req`  out  1  memory word request.
- `mem_we`  out  1  1 = write-back word, 0 = refill read.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  write-back data.
- `mem_rdata`  in  32  refill data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle pulse completing the current word.

## Operation
- Per line: `valid`, `dirty`, tag, LINE_WORDS data words.
- `lookup_hit` = `valid[index]` & tag match.
- `hit` = `~en | (state==IDLE & lookup_hit)`. Combinational; no cycle of latency on a hit.
- Load hit: `rdata` = data[index][offset], combinational.
- Store hit: word written at the clock edge and `dirty[index]` set.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, `en & ~lookup_hit`:
  - Latch index, the old tag, and the new tag.
  - Clear the word counter.
  - Go to WRITEBACK if the victim is valid & dirty; otherwise go to REFILL.
- WRITEBACK:
  - `mem_req=1`, `mem_we=1`.
  - `mem_addr` = {old tag, index, counter, 2'b00}; `mem_wdata` = stored word.
  - Each `mem_ack` increments the counter.
  - The ack on word LINE_WORDS-1 clears the counter and moves to REFILL.
- REFILL:
  - `mem_req=1`, `mem_we=0`, `mem_addr` = {new tag, index, counter, 2'b00}.
  - Each `mem_ack` writes `mem_rdata` into word[counter].
  - The last ack sets valid=1, dirty=0, tag=new, and returns to IDLE.
  - The retried access then hits in IDLE and performs the store or load normally.
- `addr`/`we`/`wdata` are held stable by the core while `hit=0`. The refill uses the latched address regardless.
- `mem_ack` while `mem_req=0` is ignored.
- Counter width is OFFSET_WIDTH. It wraps to 0 naturally after the last word.

## Timing
- Reset (`reset=0` at an edge):
  - state=IDLE, counter=0, all `valid` and `dirty` cleared (data and tags are not cleared).
  - Next cycle: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `hit` = `~en`.
- Reset mid-WRITEBACK/REFILL: the line is abandoned (it stays invalid) and the same-cycle `mem_ack` is ignored. The memory side must tolerate the dropped request.
- Hit latency: 0 cycles.
- Clean miss: `hit` low for LINE_WORDS acks plus 1 cycle (the return-to-IDLE cycle, where it hits).
- Dirty miss: 2×LINE_WORDS acks plus 1.
- `mem_req`, `mem_we`, `mem_addr`, and `mem_wdata` are registered or derived from state. They stay stable until the ack and change only on the edge that samples the ack.
- Ack in the same cycle as request: allowed, and counts.
- Store hit and a miss to another index cannot coincide, because there is a single request port.

## Structure
- Package `dcache_pkg`:
  - `dcache_state_t` enum (IDLE, WRITEBACK, REFILL).
  - Default parameter constants.
  - Address-field extraction functions.
- Sub-module `dcache_line_store`: valid/dirty/tag/data arrays with async read, a sync write port, and a reset clearing valid/dirty.
- `dcache_ctrl`: FSM, counter, latches, hit logic.

## Test plan
Defaults are SET_WIDTH=4, OFFSET_WIDTH=2; memory acks 2 cycles after the request.
1. Reset, then `en=0`, addr=0xFFFF_FFFC → `hit=1`, `mem_req=0` throughout; a spurious `mem_ack` causes no state change.
2. Load 0x0000_0100 cold, memory returning 0x11, 0x22, 0x33, 0x44 at 0x100–0x10C →
   - `hit=0`, four reads at 0x100, 0x104, 0x108, 0x10C.
   - Then `hit=1` with `rdata=0x11`.
   - A following load of 0x108 hits at once with `rdata=0x33`.
3. Store 0xDEAD_BEEF to 0x104 after test 2 → `hit=1` same cycle, no `mem_req`; a load of 0x104 returns 0xDEAD_BEEF.
4. Load 0x0000_0200 (same index 0, different tag) after test 3 →
   - Write-back of 0x100=0x11, 0x104=0xDEAD_BEEF, 0x108=0x33, 0x10C=0x44.
   - Then refill reads from 0x200–0x20C.
   - `hit` rises after 9 acks' worth of cycles.
5. Reset asserted after the 2nd refill ack of a 0x300 miss → `mem_req=0` next cycle; a load of 0x300 afterwards misses again with a full refill.
6. Load 0x0000_0104 after a clean refill, then eviction by 0x0000_1104 → no write-back (`mem_we` never 1), refill only.
